// File: rtl/hh_frame_source_pkg.sv
// Shared types, constants and sizing helpers for the HitchHike frame source
// and its companion bit timer.
`timescale 1ns/1ps
package hh_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_TAIL,
        ST_HOLD
    } hh_state_e;

    localparam logic [47:0] HH_PREAMBLE_0x92x6 = {6{8'h92}};

    function automatic int unsigned hh_frame_bits(input int unsigned pre_w,
                                                  input int unsigned pay_w,
                                                  input int unsigned rep,
                                                  input int unsigned tail_w);
        return pre_w + pay_w * rep + tail_w;
    endfunction

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int unsigned hh_cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned hh_max3(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hh_frame_source_if.sv
// Control and serial-output bundle between a frame-source controller and the
// frame source itself.
`timescale 1ns/1ps
interface hh_frame_source_if #(
    parameter int unsigned PAYLOAD_W = 10
);
    logic                 trigger;
    logic                 loop;
    logic                 load_valid;
    logic [PAYLOAD_W-1:0] load_data;
    logic                 data_out;
    logic                 bit_strobe;
    logic                 busy;
    logic                 frame_done;

    modport master (
        output trigger, loop, load_valid, load_data,
        input  data_out, bit_strobe, busy, frame_done
    );

    modport slave (
        input  trigger, loop, load_valid, load_data,
        output data_out, bit_strobe, busy, frame_done
    );
endinterface

// File: rtl/hh_bit_timer.sv
// Bit-period divider: counts 0..BIT_PERIOD-1 and flags count 0 as the tick.
`timescale 1ns/1ps
module hh_bit_timer
    import hh_source_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 50,
    parameter int unsigned CNT_W      = hh_cnt_w(BIT_PERIOD)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    output logic tick_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || count_q == CNT_W'(BIT_PERIOD - 1)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == '0);

endmodule

// File: rtl/hh_frame_source.sv
// Serial frame generator: preamble, REP-times repeated payload, zero tail,
// one bit per BIT_PERIOD clocks while trigger is held high.
`timescale 1ns/1ps
module hh_frame_source
    import hh_source_pkg::*;
#(
    parameter int unsigned             PAYLOAD_W       = 10,
    parameter int unsigned             REP             = 3,
    parameter int unsigned             PREAMBLE_W      = 48,
    parameter logic [PREAMBLE_W-1:0]   PREAMBLE        = HH_PREAMBLE_0x92x6,
    parameter int unsigned             TAIL_W          = 24,
    parameter int unsigned             BIT_PERIOD      = 50,
    parameter logic [PAYLOAD_W-1:0]    DEFAULT_PAYLOAD = 10'b10_1010_1010
) (
    input  logic             clock,
    input  logic             reset,
    hh_frame_source_if.slave bus
);

    localparam int unsigned FIELD_W = hh_cnt_w(hh_max3(PREAMBLE_W, PAYLOAD_W, TAIL_W));
    localparam int unsigned REP_W   = hh_cnt_w(REP);

    hh_state_e            state_q, state_d;
    logic [FIELD_W-1:0]   field_q, field_d;
    logic [REP_W-1:0]     rep_q, rep_d;
    logic [PAYLOAD_W-1:0] shadow_q, shadow_d;
    logic [PAYLOAD_W-1:0] work_q, work_d;
    logic                 data_q, data_d;
    logic                 strobe_q, strobe_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 timer_clear;
    logic                 start;
    logic                 finish;

    function automatic logic pre_bit(input logic [FIELD_W-1:0] idx);
        logic [PREAMBLE_W-1:0] s;
        s = PREAMBLE << idx;
        return s[PREAMBLE_W-1];
    endfunction

    function automatic logic pay_bit(input logic [PAYLOAD_W-1:0] p,
                                     input logic [FIELD_W-1:0]   idx);
        logic [PAYLOAD_W-1:0] s;
        s = p << idx;
        return s[PAYLOAD_W-1];
    endfunction

    // Divider free-runs through field and frame boundaries; it is only held
    // at zero while idle-able, so the first bit lands on the trigger edge.
    assign timer_clear = !bus.trigger || (state_q == ST_HOLD);

    hh_bit_timer #(
        .BIT_PERIOD(BIT_PERIOD)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear_i(timer_clear),
        .tick_o (tick)
    );

    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        rep_d    = rep_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        work_d   = work_q;
        shadow_d = bus.load_valid ? bus.load_data : shadow_q;
        start    = 1'b0;
        finish   = 1'b0;

        if (!bus.trigger) begin
            state_d = ST_IDLE;
            field_d = '0;
            rep_d   = '0;
            data_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: start = 1'b1;
                ST_PREAMBLE: if (tick) begin
                    strobe_d = 1'b1;
                    if (field_q == FIELD_W'(PREAMBLE_W - 1)) begin
                        state_d = ST_PAYLOAD;
                        field_d = '0;
                        rep_d   = '0;
                        data_d  = pay_bit(work_q, '0);
                    end else begin
                        field_d = field_q + FIELD_W'(1);
                        data_d  = pre_bit(field_q + FIELD_W'(1));
                    end
                end
                ST_PAYLOAD: if (tick) begin
                    strobe_d = 1'b1;
                    if (rep_q != REP_W'(REP - 1)) begin
                        rep_d = rep_q + REP_W'(1);
                    end else if (field_q != FIELD_W'(PAYLOAD_W - 1)) begin
                        field_d = field_q + FIELD_W'(1);
                        rep_d   = '0;
                        data_d  = pay_bit(work_q, field_q + FIELD_W'(1));
                    end else if (TAIL_W != 0) begin
                        state_d = ST_TAIL;
                        field_d = '0;
                        rep_d   = '0;
                        data_d  = 1'b0;
                    end else begin
                        finish = 1'b1;
                    end
                end
                ST_TAIL: if (tick) begin
                    if (field_q == FIELD_W'(TAIL_W - 1)) begin
                        finish = 1'b1;
                    end else begin
                        strobe_d = 1'b1;
                        field_d  = field_q + FIELD_W'(1);
                        data_d   = 1'b0;
                    end
                end
                ST_HOLD: data_d = 1'b0;
                default: state_d = ST_IDLE;
            endcase
        end

        if (finish) begin
            done_d   = 1'b1;
            strobe_d = 1'b0;
            if (bus.loop) begin
                start = 1'b1;
            end else begin
                state_d = ST_HOLD;
                field_d = '0;
                rep_d   = '0;
                data_d  = 1'b0;
            end
        end

        // shadow_d already carries a same-cycle load, so it bypasses into the frame
        if (start) begin
            state_d  = ST_PREAMBLE;
            field_d  = '0;
            rep_d    = '0;
            work_d   = shadow_d;
            data_d   = pre_bit('0);
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            field_q  <= '0;
            rep_q    <= '0;
            shadow_q <= DEFAULT_PAYLOAD;
            work_q   <= DEFAULT_PAYLOAD;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            field_q  <= field_d;
            rep_q    <= rep_d;
            shadow_q <= shadow_d;
            work_q   <= work_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.bit_strobe = strobe_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = (state_q == ST_PREAMBLE) || (state_q == ST_PAYLOAD) ||
                            (state_q == ST_TAIL);

endmodule
